// File: rtl/mem1_stage.sv
// mem1_stage: first memory stage; issues the RAM request, waits on ram_ready and right-aligns the read word.
// Optional MISALIGN_TRAP_EN: misaligned accesses skip the RAM and raise misalign_out instead.
`ifndef OPC_LOAD
`define OPC_LOAD 7'b0000011
`endif
`ifndef OPC_STORE
`define OPC_STORE 7'b0100011
`endif
`ifndef FUNCT3_B
`define FUNCT3_B 2'b00
`endif
`ifndef FUNCT3_H
`define FUNCT3_H 2'b01
`endif
`ifndef FUNCT3_W
`define FUNCT3_W 2'b10
`endif
module mem1_stage #(
  parameter int RAM_AW = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [6:0]        opcode_in,
  input  logic [2:0]        funct3_in,
  input  logic [31:0]       alu_result_in,
  input  logic [31:0]       rs2_data_in,
  input  logic [4:0]        rd_addr_in,
  input  logic              flush,
  output logic              stall_out,
  output logic              ram_req,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic              ram_ready,
  input  logic [31:0]       ram_rdata,
  output logic              valid_out,
  output logic [6:0]        opcode_out,
  output logic [2:0]        funct3_out,
  output logic [31:0]       rd_data_out,
  output logic [31:0]       ram_data_out,
  output logic [4:0]        rd_addr_out,
  output logic              misalign_out
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_nx;
  logic mem_op, trap, issue, busy, kill_q, we_q;
  logic [1:0] sz, off, eoff, sh_q;
  logic [3:0] be, be_q;
  logic [31:0] wdata, wdata_q, alu_q, rdata_al;
  logic [RAM_AW-1:0] addr_q;
  logic [6:0] op_q;
  logic [2:0] f3_q;
  logic [4:0] rd_q;
  assign sz = funct3_in[1:0];
  assign off = alu_result_in[1:0];
  assign mem_op = valid_in & (opcode_in == `OPC_LOAD | opcode_in == `OPC_STORE) & !flush;
`ifdef MISALIGN_TRAP_EN
  assign trap = mem_op & (sz == `FUNCT3_H ? off[0] : sz != `FUNCT3_B & off != 2'b00);
`else
  assign trap = 1'b0;
`endif
  // Without the trap, misaligned low offset bits are simply dropped.
  assign eoff = sz == `FUNCT3_B ? off : sz == `FUNCT3_H ? {off[1], 1'b0} : 2'b00;
  assign be = (sz == `FUNCT3_B ? 4'b0001 : sz == `FUNCT3_H ? 4'b0011 : 4'b1111) << eoff;
  assign wdata = sz == `FUNCT3_B ? {4{rs2_data_in[7:0]}} :
                 sz == `FUNCT3_H ? {2{rs2_data_in[15:0]}} : rs2_data_in;
  assign issue = mem_op & !trap;
  assign busy = state == WAIT;
  assign rdata_al = ram_rdata >> {(busy ? sh_q : eoff), 3'b000};
  always_comb begin
    ram_req = rst_n & (busy | issue);
    ram_we = busy ? we_q : opcode_in == `OPC_STORE;
    ram_be = busy ? be_q : be;
    ram_addr = busy ? addr_q : alu_result_in[RAM_AW+1:2];
    ram_wdata = busy ? wdata_q : wdata;
    stall_out = ram_req & !ram_ready;
    state_nx = stall_out ? WAIT : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      valid_out <= 1'b0;
      opcode_out <= '0;
      funct3_out <= '0;
      rd_data_out <= '0;
      ram_data_out <= '0;
      rd_addr_out <= '0;
      misalign_out <= 1'b0;
      kill_q <= 1'b0;
      we_q <= 1'b0;
      be_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      sh_q <= '0;
      op_q <= '0;
      f3_q <= '0;
      alu_q <= '0;
      rd_q <= '0;
    end else begin
      state <= state_nx;
      if (busy) begin
        kill_q <= kill_q | flush;
        valid_out <= ram_ready & !(kill_q | flush);
        if (ram_ready) begin
          opcode_out <= op_q;
          funct3_out <= f3_q;
          rd_data_out <= alu_q;
          rd_addr_out <= rd_q;
          ram_data_out <= rdata_al;
          misalign_out <= 1'b0;
        end
      end else if (stall_out) begin
        valid_out <= 1'b0;
        kill_q <= 1'b0;
        we_q <= ram_we;
        be_q <= be;
        addr_q <= ram_addr;
        wdata_q <= wdata;
        sh_q <= eoff;
        op_q <= opcode_in;
        f3_q <= funct3_in;
        alu_q <= alu_result_in;
        rd_q <= rd_addr_in;
      end else begin
        valid_out <= valid_in & !flush;
        if (valid_in & !flush) begin
          opcode_out <= opcode_in;
          funct3_out <= funct3_in;
          rd_data_out <= alu_result_in;
          rd_addr_out <= rd_addr_in;
          ram_data_out <= issue ? rdata_al : 32'd0;
          misalign_out <= trap;
        end
      end
    end
  end
endmodule

// File: doc/mem1_stage.md
Name: mem1_stage

Overview:
- First memory stage of the dOrv32 pipeline. Sits between EX and mem2_.
- Registers the EX result and issues the RAM request: word address, byte enables, and lane-replicated store data.
- Waits on a RAM ready handshake and right-aligns the returned word by byte offset. mem2_ then only sign- or zero-extends from bit 0.
- Stalls upstream while a RAM access is outstanding.

Parameters:
- RAM_AW, 14: RAM word-address width; ram_addr = alu_result_in[RAM_AW+1:2].

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- valid_in  in  1  EX slot holds a real instruction
- opcode_in  in  7  instruction opcode (`OPC_* defines)
- funct3_in  in  3  funct3 (`FUNCT3_B/H/W in [1:0], unsigned flag in [2])
- alu_result_in  in  32  memory byte address for load/store; rd value otherwise
- rs2_data_in  in  32  store data
- rd_addr_in  in  5  destination register
- flush  in  1  squash the instruction entering this stage
- stall_out  out  1  upstream must hold its inputs
- ram_req  out  1  access request
- ram_we  out  1  1 = write
- ram_be  out  4  byte enables
- ram_addr  out  RAM_AW  word address
- ram_wdata  out  32  lane-replicated store data
- ram_ready  in  1  access accepted/completed this cycle; read data valid on ram_rdata
- ram_rdata  in  32  raw read word
- valid_out  out  1  mem2_ slot valid
- opcode_out  out  7  to mem2_ opcode_in
- funct3_out  out  3  to mem2_ funct3_in
- rd_data_out  out  32  to mem2_ rd_data_in (registered alu_result_in)
- ram_data_out  out  32  to mem2_ ram_data (offset-aligned read word)
- rd_addr_out  out  5  destination register
- misalign_out  out  1  misaligned-access flag

Behaviour:
- Reset:
  - State goes to IDLE.
  - All registered outputs go to 0: valid_out, opcode_out, funct3_out, rd_data_out, ram_data_out, rd_addr_out, misalign_out.
  - ram_req=0, stall_out=0.
- Memory op: valid_in & (opcode == `OPC_LOAD | opcode == `OPC_STORE) & !flush.
- Lane rules, with off = alu_result_in[1:0]:
  - B: be = 4'b0001 << off; wdata = {4{rs2[7:0]}}; rdata aligned = ram_rdata >> 8*off.
  - H: be = off[1] ? 4'b1100 : 4'b0011; wdata = {2{rs2[15:0]}}; aligned = ram_rdata >> 16*off[1].
  - W: be = 4'b1111; wdata = rs2; aligned = ram_rdata unshifted.
- IDLE state:
  - Memory op: ram_req, ram_we, ram_be, ram_addr and ram_wdata are driven combinationally from the inputs in the same cycle.
  - If ram_ready is also high: capture the result at the clock edge (latency 1), valid_out=1, stay in IDLE.
  - If ram_ready is low: stall_out=1 combinationally, latch the request fields, go to WAIT.
  - Non-memory op: ram_req=0; fields pass through with 1-cycle latency; ram_data_out=0.
  - valid_in=0 or flush: bubble next cycle (valid_out=0; other outputs don't-care but held).
- WAIT state:
  - ram_req is held with the latched fields; stall_out=1; valid_out=0 each cycle.
  - On ram_ready: capture aligned data, valid_out=1 next cycle, return to IDLE. stall_out falls in that same cycle, so upstream advances.
  - Request fields must not change while waiting.
- Flush during WAIT:
  - The RAM transaction still completes: ram_req stays asserted until ram_ready; stores are committed.
  - A sticky kill bit is set; on completion valid_out=0 instead of 1.
- Back-to-back memory ops with ram_ready held high: one access per cycle, no bubbles.
- rd_data_out is always alu_result_in, registered. mem2_ selects ram_data_out only for loads.
- Asynchronous reset mid-WAIT:
  - ram_req drops immediately.
  - The partial transaction is abandoned; the RAM side is reset by the same rst_n.
- Misaligned definitions: H with off[0]=1; W with off != 0.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A misaligned access issues no RAM request (ram_req=0, no stall).
  - Next cycle valid_out=1, misalign_out=1, and rd_data_out holds the faulting address for the trap unit.
- Undefined:
  - misalign_out is tied 0.
  - The access is issued with the offending low offset bits cleared (H uses off[1] only; W uses off=0).

Test Plan:
- SW x=0xDEADBEEF to addr 0x104, ram_ready=1 -> same cycle ram_req=1, ram_we=1, ram_be=4'b1111, ram_addr=0x41, ram_wdata=0xDEADBEEF; next cycle valid_out=1, stall_out never high.
- LB addr 0x203, ram_rdata=0x80123456, ram_ready=1 -> ram_be=4'b1000; ram_data_out=0x00000080; mem2_ yields 0xFFFFFF80 (LB) or 0x00000080 (LBU).
- LH addr 0x002, ram_ready low for 3 cycles -> stall_out=1 for exactly 3 cycles; WAIT holds ram_be=4'b1100; on ready ram_data_out = ram_rdata>>16, valid_out=1 one cycle later.
- LW in WAIT, flush asserted in cycle 2 -> ram_req held until ram_ready; completion gives valid_out=0; next instruction proceeds normally.
- ADD result 0x12345678, valid_in=1 -> ram_req=0; next cycle rd_data_out=0x12345678, valid_out=1. valid_in=0 -> valid_out=0.
- SH addr 0x001 -> with MISALIGN_TRAP_EN: ram_req=0, misalign_out=1, rd_data_out=0x001. Without: ram_be=4'b0011, misalign_out=0.
